axibus2rambus: RTL and testbench
================================

AXIBUS2RAMBUS -- requirements
Module: axibus2rambus

Interface
REQ-001 SHALL have parameter C_M_AXI_LEN_WIDTH, default 32, AXI length field width.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter C_M_AXI_DATA_WIDTH, default 128, AXI read data width.
REQ-004 SHALL have parameter C_RAM_ADDR_WIDTH, default 10, RAM address and length width.
REQ-005 SHALL have parameter C_RAM_DATA_WIDTH, default 128, RAM write data width; equals C_M_AXI_DATA_WIDTH.
REQ-006 SHALL use one clock; reset is synchronous and active-high. Ports: I_clk in 1 clock; I_rst in 1 sync active-high reset.
REQ-007 SHALL have ports I_ap_start in 1 level start; O_ap_done out 1 done pulse; O_ap_idle out 1 idle; O_ap_ready out 1 ready pulse.
REQ-008 SHALL have ports I_base_addr in C_M_AXI_ADDR_WIDTH DDR source address; I_len in C_RAM_ADDR_WIDTH beat count.
REQ-009 SHALL have ports O_maxi_araddr out C_M_AXI_ADDR_WIDTH; O_maxi_arlen out C_M_AXI_LEN_WIDTH; O_maxi_arvalid out 1; I_maxi_arready in 1.
REQ-010 SHALL have ports I_maxi_rvalid in 1; I_maxi_rdata in C_M_AXI_DATA_WIDTH; I_maxi_rlast in 1; I_maxi_rresp in 2; O_maxi_rready out 1.
REQ-011 SHALL have ports O_waddr out C_RAM_ADDR_WIDTH; O_wr out 1; O_wdata out C_RAM_DATA_WIDTH (RAM write bus).

Function
REQ-012 SHALL implement FSM states IDLE, ADDR, DATA, DONE.
REQ-013 IDLE->ADDR on rising edge of I_ap_start (start high, previous cycle low) with I_len != 0. IDLE->DONE on rising edge with I_len == 0; no AR issued.
REQ-014 On leaving IDLE, SHALL latch I_base_addr into O_maxi_araddr and zero-extended I_len into O_maxi_arlen; both hold until the next start.
REQ-015 In ADDR, O_maxi_arvalid SHALL be 1. On arvalid&&arready it SHALL move to DATA, with arvalid 0 the next cycle. Arvalid is never withdrawn before the handshake.
REQ-016 In DATA, O_maxi_rready SHALL be 1. Each rvalid&&rready beat is accepted.
REQ-017 Each accepted beat SHALL produce O_wr=1 one cycle later, with O_wdata=registered rdata and O_waddr=beat index (0..len-1).
REQ-018 Beat counter width is C_RAM_ADDR_WIDTH. On the beat where count reaches len-1, DATA->DONE and rready deasserts the next cycle. Completion depends on count only; I_maxi_rlast does not affect it.
REQ-019 In DONE, O_ap_done and O_ap_ready SHALL pulse high exactly one cycle, then the FSM returns to IDLE. A new start requires I_ap_start low then high.
REQ-020 O_ap_idle SHALL be 1 in IDLE and 0 in all other states.
REQ-021 I_ap_start low in ADDR or DATA SHALL abort to IDLE next cycle: arvalid=0, rready=0, no further O_wr after the pipelined write of any beat already accepted, no done pulse.
REQ-022 Latency: start edge -> arvalid 1 cycle. Last beat accepted -> last O_wr 1 cycle -> O_ap_done 2 cycles.

Reset
REQ-023 I_rst SHALL force IDLE and clear the beat counter. Output reset values: O_maxi_arvalid=0, O_maxi_rready=0, O_wr=0, O_ap_done=0, O_ap_ready=0, O_ap_idle=1, O_maxi_araddr=0, O_maxi_arlen=0, O_waddr=0, O_wdata=0.
REQ-024 I_rst asserted mid-transfer SHALL take precedence over all other inputs. The start edge detector SHALL be cleared so that a start held high across reset release begins a new run.

Configuration
REQ-025 Macro AXIBUS2RAMBUS_RRESP_CHK_EN, when defined, SHALL add output O_rerr (1 bit). O_rerr is set on any accepted beat with I_maxi_rresp != 2'b00, held until the next start edge or reset, and cleared to 0 at reset.
REQ-026 Without AXIBUS2RAMBUS_RRESP_CHK_EN, O_rerr SHALL NOT exist and I_maxi_rresp SHALL be ignored.

Verification
REQ-027 I_base_addr=0x1000, I_len=4, arready on the first cycle, rvalid continuous -> araddr=0x1000, arlen=4; O_wr on 4 consecutive cycles at addr 0..3 with matching data; done one pulse 2 cycles after the 4th beat.
REQ-028 I_len=8, rvalid toggling 1010... -> exactly 8 O_wr at addr 0..7 in order; no write on rvalid-low cycles.
REQ-029 arready held low 5 cycles -> arvalid stays 1 for 6 cycles; no rready before the handshake.
REQ-030 I_len=0 -> no arvalid, no O_wr, done pulse 2 cycles after the start edge, then idle=1.
REQ-031 ap_start dropped after 2 of 6 beats -> FSM in IDLE, rready=0, only addr 0,1 written, no done; a new start with I_len=3 completes normally.
REQ-032 With AXIBUS2RAMBUS_RRESP_CHK_EN, rresp=2'b10 on beat 1 of 4 -> O_rerr=1 from the cycle after beat 1; all 4 beats still written; O_rerr clears on the next start edge.

Source files
------------

// File: rtl/axibus2rambus.sv
`default_nettype none
// ============================================================================
// Module      : axibus2rambus
// Description : Fetches I_len beats from DDR over an AXI read channel and
//               writes them into a local RAM, under ap_ctrl handshake.
//               Optional macro AXIBUS2RAMBUS_RRESP_CHK_EN adds O_rerr.
// Revision    : 1.0 - initial release
// ============================================================================
module axibus2rambus #(
    parameter int C_M_AXI_LEN_WIDTH  = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int C_RAM_ADDR_WIDTH   = 10,
    parameter int C_RAM_DATA_WIDTH   = 128
) (
    input  logic                          I_clk,
    input  logic                          I_rst,
    input  logic                          I_ap_start,
    output logic                          O_ap_done,
    output logic                          O_ap_idle,
    output logic                          O_ap_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr,
    input  logic [C_RAM_ADDR_WIDTH-1:0]   I_len,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] O_maxi_araddr,
    output logic [C_M_AXI_LEN_WIDTH-1:0]  O_maxi_arlen,
    output logic                          O_maxi_arvalid,
    input  logic                          I_maxi_arready,
    input  logic                          I_maxi_rvalid,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] I_maxi_rdata,
    input  logic                          I_maxi_rlast,
    input  logic [1:0]                    I_maxi_rresp,
    output logic                          O_maxi_rready,
    output logic [C_RAM_ADDR_WIDTH-1:0]   O_waddr,
    output logic                          O_wr,
    output logic [C_RAM_DATA_WIDTH-1:0]   O_wdata
`ifdef AXIBUS2RAMBUS_RRESP_CHK_EN
    ,
    output logic                          O_rerr
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [C_RAM_ADDR_WIDTH-1:0] c_cnt_one = {{(C_RAM_ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                      r_state;
    state_t                      w_next;
    logic                        r_start_d;
    logic                        r_done_phase;
    logic [C_RAM_ADDR_WIDTH-1:0] r_cnt;
    logic [C_RAM_ADDR_WIDTH-1:0] r_len;
    logic                        w_start_rise;
    logic                        w_launch;
    logic                        w_beat;
    logic                        w_last;

    // Completion is count based; rlast is deliberately not consulted.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, I_maxi_rlast, I_maxi_rresp};

    assign w_start_rise = I_ap_start & ~r_start_d;
    assign w_launch     = (r_state == S_IDLE) & w_start_rise;
    assign w_beat       = (r_state == S_DATA) & I_maxi_rvalid;
    assign w_last       = w_beat & (r_cnt == (r_len - c_cnt_one));

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state      <= S_IDLE;
            r_start_d    <= 1'b0;
            r_done_phase <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_start_d    <= I_ap_start;
            // DONE lasts two cycles so the pulse trails the final RAM write.
            r_done_phase <= (r_state == S_DONE) & ~r_done_phase;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_rise) begin
                    w_next = (I_len != '0) ? S_ADDR : S_DONE;
                end
            end
            S_ADDR: begin
                if (!I_ap_start) begin
                    w_next = S_IDLE;
                end else if (I_maxi_arready) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (!I_ap_start) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (r_done_phase) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        O_maxi_arvalid = (r_state == S_ADDR);
        O_maxi_rready  = (r_state == S_DATA);
        O_ap_idle      = (r_state == S_IDLE);
        O_ap_done      = (r_state == S_DONE) & r_done_phase;
        O_ap_ready     = (r_state == S_DONE) & r_done_phase;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_maxi_araddr <= '0;
            O_maxi_arlen  <= '0;
            r_len         <= '0;
        end else if (w_launch) begin
            O_maxi_araddr <= I_base_addr;
            O_maxi_arlen  <= C_M_AXI_LEN_WIDTH'(I_len);
            r_len         <= I_len;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_cnt   <= '0;
            O_wr    <= 1'b0;
            O_waddr <= '0;
            O_wdata <= '0;
        end else begin
            O_wr <= w_beat;
            if (w_launch) begin
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
            if (w_beat) begin
                O_waddr <= r_cnt;
                O_wdata <= I_maxi_rdata;
            end
        end
    end

`ifdef AXIBUS2RAMBUS_RRESP_CHK_EN
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_rerr <= 1'b0;
        end else if (w_launch) begin
            O_rerr <= 1'b0;
        end else if (w_beat && (I_maxi_rresp != 2'b00)) begin
            O_rerr <= 1'b1;
        end
    end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_axibus2rambus.sv
`default_nettype none
// ============================================================================
// Module      : tb_axibus2rambus
// Description : Scoreboard bench for axibus2rambus RAM write stream and
//               ap_ctrl / AXI AR / R handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axibus2rambus;

    typedef struct packed {
        logic [9:0]   addr;
        logic [127:0] data;
    } wr_t;

    logic         clk;
    logic         rst;
    logic         ap_start;
    logic         ap_done;
    logic         ap_idle;
    logic         ap_ready;
    logic [31:0]  base_addr;
    logic [9:0]   len;
    logic [31:0]  araddr;
    logic [31:0]  arlen;
    logic         arvalid;
    logic         arready;
    logic         rvalid;
    logic [127:0] rdata;
    logic         rlast;
    logic [1:0]   rresp;
    logic         rready;
    logic [9:0]   waddr;
    logic         wr;
    logic [127:0] wdata;
`ifdef AXIBUS2RAMBUS_RRESP_CHK_EN
    logic         rerr;
`endif

    int  n_checks = 0;
    int  n_fail   = 0;
    int  wr_count = 0;
    int  done_count = 0;
    wr_t exp_q[$];

    axibus2rambus dut (
        .I_clk          (clk),
        .I_rst          (rst),
        .I_ap_start     (ap_start),
        .O_ap_done      (ap_done),
        .O_ap_idle      (ap_idle),
        .O_ap_ready     (ap_ready),
        .I_base_addr    (base_addr),
        .I_len          (len),
        .O_maxi_araddr  (araddr),
        .O_maxi_arlen   (arlen),
        .O_maxi_arvalid (arvalid),
        .I_maxi_arready (arready),
        .I_maxi_rvalid  (rvalid),
        .I_maxi_rdata   (rdata),
        .I_maxi_rlast   (rlast),
        .I_maxi_rresp   (rresp),
        .O_maxi_rready  (rready),
        .O_waddr        (waddr),
        .O_wr           (wr),
        .O_wdata        (wdata)
`ifdef AXIBUS2RAMBUS_RRESP_CHK_EN
        ,
        .O_rerr         (rerr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RAM-side monitor: every write must match the oldest expected beat.
    always @(posedge clk) begin
        wr_t e;
        #2;
        if (wr === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", waddr, e.addr);
                check("wr_data", wdata, e.data);
            end
        end
        if (ap_done === 1'b1) done_count++;
    end

    task automatic begin_run(input logic [31:0] b, input logic [9:0] l);
        ap_start = 1'b0;
        tick();
        base_addr = b;
        len       = l;
        ap_start  = 1'b1;
        tick();
    endtask

    task automatic addr_phase(input logic [31:0] b, input logic [9:0] l, input int ar_delay);
        check("arvalid_on", arvalid, 1);
        check("araddr", araddr, b);
        check("arlen", arlen, {22'd0, l});
        check("idle_busy", ap_idle, 0);
        for (int d = 0; d < ar_delay; d++) begin
            check("arvalid_hold", arvalid, 1);
            check("rready_pre_hs", rready, 0);
            arready = 1'b0;
            tick();
        end
        check("arvalid_last", arvalid, 1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("arvalid_off", arvalid, 0);
        check("rready_on", rready, 1);
    endtask

    task automatic data_phase(input int l, input bit toggle, input int abort_after, input int err_idx);
        int beats = 0;
        for (int i = 0; i < 400 && beats < l; i++) begin
            check("rready_data", rready, 1);
            if (abort_after >= 0 && beats == abort_after) begin
                ap_start = 1'b0;
                rvalid   = 1'b0;
                tick();
                break;
            end
            rvalid = toggle ? (i % 2 == 0) : 1'b1;
            rresp  = (rvalid && beats == err_idx) ? 2'b10 : 2'b00;
            if (rvalid) begin
                rdata = {$urandom, $urandom, $urandom, $urandom};
                exp_q.push_back({beats[9:0], rdata});
                beats++;
            end
            tick();
`ifdef AXIBUS2RAMBUS_RRESP_CHK_EN
            if (err_idx >= 0) check("rerr_track", rerr, (beats > err_idx) ? 1 : 0);
`endif
        end
        rvalid = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic done_phase();
        check("rready_drop", rready, 0);
        check("done_early", ap_done, 0);
        check("idle_in_done", ap_idle, 0);
        tick();
        check("done_pulse", ap_done, 1);
        check("ready_pulse", ap_ready, 1);
        tick();
        check("done_clear", ap_done, 0);
        check("ready_clear", ap_ready, 0);
        check("idle_back", ap_idle, 1);
    endtask

    task automatic full_run(input logic [31:0] b, input logic [9:0] l, input int ar_delay, input bit toggle);
        int w0 = wr_count;
        int d0 = done_count;
        begin_run(b, l);
        addr_phase(b, l, ar_delay);
        data_phase(int'(l), toggle, -1, -1);
        done_phase();
        tick();
        check("run_wr_count", wr_count - w0, l);
        check("run_done_count", done_count - d0, 1);
        check("run_q_empty", exp_q.size(), 0);
        check("araddr_hold", araddr, b);
    endtask

    initial begin
        int w0;
        int d0;
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        rst = 1'b1; ap_start = 1'b0; base_addr = '0; len = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
        repeat (3) tick();
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_wr", wr, 0);
        check("rst_done", ap_done, 0);
        check("rst_ready", ap_ready, 0);
        check("rst_idle", ap_idle, 1);
        check("rst_araddr", araddr, 0);
        check("rst_arlen", arlen, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        rst = 1'b0;
        tick();

        full_run(32'h1000, 10'd4, 0, 1'b0);
        full_run(32'h1100, 10'd8, 0, 1'b1);
        full_run(32'h1200, 10'd2, 5, 1'b0);
        full_run(32'h1300, 10'd1, 1, 1'b1);

        // Zero-length request completes without touching AXI or RAM.
        w0 = wr_count; d0 = done_count;
        begin_run(32'h2000, 10'd0);
        check("len0_arvalid", arvalid, 0);
        check("len0_done_early", ap_done, 0);
        check("len0_idle", ap_idle, 0);
        tick();
        check("len0_arvalid2", arvalid, 0);
        check("len0_done", ap_done, 1);
        tick();
        check("len0_done_clear", ap_done, 0);
        check("len0_idle_back", ap_idle, 1);
        tick();
        check("len0_wr", wr_count - w0, 0);
        check("len0_done_count", done_count - d0, 1);

        // Abort after two beats, then a clean restart.
        w0 = wr_count; d0 = done_count;
        begin_run(32'h3000, 10'd6);
        addr_phase(32'h3000, 10'd6, 0);
        data_phase(6, 1'b0, 2, -1);
        check("abort_idle", ap_idle, 1);
        check("abort_rready", rready, 0);
        check("abort_arvalid", arvalid, 0);
        repeat (4) tick();
        check("abort_wr_count", wr_count - w0, 2);
        check("abort_no_done", done_count - d0, 0);
        check("abort_q_empty", exp_q.size(), 0);
        full_run(32'h4000, 10'd3, 0, 1'b0);

        // Reset mid-transfer with start held high restarts the run.
        w0 = wr_count;
        begin_run(32'h5000, 10'd4);
        addr_phase(32'h5000, 10'd4, 0);
        rvalid = 1'b1;
        rdata  = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back({10'd0, rdata});
        tick();
        rvalid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("mrst_arvalid", arvalid, 0);
        check("mrst_rready", rready, 0);
        check("mrst_wr", wr, 0);
        check("mrst_idle", ap_idle, 1);
        check("mrst_araddr", araddr, 0);
        check("mrst_arlen", arlen, 0);
        rst = 1'b0;
        tick();
        d0 = done_count;
        addr_phase(32'h5000, 10'd4, 1);
        data_phase(4, 1'b0, -1, -1);
        done_phase();
        tick();
        check("mrst_wr_count", wr_count - w0, 5);
        check("mrst_done_count", done_count - d0, 1);

`ifdef AXIBUS2RAMBUS_RRESP_CHK_EN
        begin_run(32'h6000, 10'd4);
        check("rerr_init", rerr, 0);
        addr_phase(32'h6000, 10'd4, 0);
        data_phase(4, 1'b0, -1, 1);
        done_phase();
        check("rerr_held", rerr, 1);
        begin_run(32'h7000, 10'd1);
        check("rerr_clear", rerr, 0);
        addr_phase(32'h7000, 10'd1, 0);
        data_phase(1, 1'b0, -1, -1);
        done_phase();
        tick();
`endif

        check("final_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
